mem_arbiter: RTL and testbench

Two-requester access controller for the shared `memory` block (32-bit read data, 20-bit write data, 256 words). It accepts valid/ready requests from two clients and selects one. It sequences the selected transaction onto the memory's single address/datain/write_en port, then returns read data or a write acknowledgement to the winning client. It sits directly in front of `memory`, and all `memory` port signals are driven only by this block.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_rr_pick.sv | 29 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-client memory arbiter.
// MEM_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
package mem_arb_pkg;

  localparam int N_REQ = 2;

  // Client 1 counts as last granted, so client 0 wins the first tie.
  localparam logic LAST_GRANT_RST = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way winner select over the eligible clients.
// MEM_ARB_RR_EN: tie goes to the client that was not granted last.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [N_REQ-1:0] elig,
`ifdef MEM_ARB_RR_EN
  input  logic             last_grant,
`endif
  output logic [N_REQ-1:0] grant
);

  // One-hot grant; all zero when nobody is eligible.
  always_comb begin
    grant = '0;
`ifdef MEM_ARB_RR_EN
    if (&elig)
      grant = last_grant ? 2'b01 : 2'b10;
    else
      grant = elig;
`else
    if (elig[0])
      grant = 2'b01;
    else if (elig[1])
      grant = 2'b10;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two valid/ready clients onto the single memory port.
// MEM_ARB_RR_EN enables round-robin; otherwise client 0 has priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int DIN_W = 20,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_we,
  input  logic [AW-1:0]    req_addr0,
  input  logic [AW-1:0]    req_addr1,
  input  logic [DIN_W-1:0] req_wdata0,
  input  logic [DIN_W-1:0] req_wdata1,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [AW-1:0]    mem_address,
  output logic [DIN_W-1:0] mem_datain,
  output logic             mem_write_en,
  input  logic [WIDTH-1:0] mem_data_out,
  input  logic             mem_full
);

  state_t state_q, state_d;

  logic             lat_we;
  logic [AW-1:0]    lat_addr;
  logic [DIN_W-1:0] lat_wdata;
  logic             owner;

  logic             open;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic             accept;
  logic             win;

  assign open = (state_q == IDLE) || (state_q == RESP);

  // Writes are held off while the memory reports full.
  assign elig = open ? (req_valid & ~(req_we & {2{mem_full}})) : 2'b00;

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  rr_pick u_pick (
    .elig       (elig),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Remember who won the last accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= LAST_GRANT_RST;
    else if (accept)
      last_grant <= win;
  end
`else
  rr_pick u_pick (
    .elig  (elig),
    .grant (grant)
  );
`endif

  assign accept    = |grant;
  assign win       = grant[1];
  assign req_ready = rst ? 2'b00 : grant;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state: accept from IDLE or RESP, otherwise walk the pipeline.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning request on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      owner     <= 1'b0;
    end else if (accept) begin
      lat_we    <= req_we[win];
      lat_addr  <= win ? req_addr1 : req_addr0;
      lat_wdata <= win ? req_wdata1 : req_wdata0;
      owner     <= win;
    end
  end

  // Capture read data at the end of CAPTURE; write acks return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rsp_rdata <= '0;
    else if (state_q == CAPTURE)
      rsp_rdata <= lat_we ? '0 : mem_data_out;
  end

  assign mem_address  = lat_addr;
  assign mem_datain   = lat_wdata;
  assign mem_write_en = (state_q == ISSUE) && lat_we;
  assign rsp_valid    = (state_q != RESP) ? 2'b00 :
                        (owner ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural memory.
// Expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int DIN_W = 20;
  localparam int AW    = 8;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] req_valid = '0, req_we = '0;
  logic [1:0] req_ready, rsp_valid;
  logic [AW-1:0] req_addr0 = '0, req_addr1 = '0, mem_address;
  logic [DIN_W-1:0] req_wdata0 = '0, req_wdata1 = '0, mem_datain;
  logic [WIDTH-1:0] rsp_rdata;
  logic [WIDTH-1:0] mem_data_out = '0;
  logic mem_write_en;
  logic mem_full = 1'b0;

  mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIN_W(DIN_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_address(mem_address), .mem_datain(mem_datain),
    .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
    .mem_full(mem_full)
  );

  always #5 clk = ~clk;

  // The memory device: write and read both complete at the clock edge.
  logic [DIN_W-1:0] dev [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (mem_write_en) dev[mem_address] <= mem_datain;
    mem_data_out <= WIDTH'(dev[mem_address]);
  end

  // Reference model: transaction-level view of the arbiter.
  typedef struct { int due; bit owner; logic [31:0] data; } rsp_t;
  rsp_t pq[$];
  logic [DIN_W-1:0] ref_mem [DEPTH] = '{default: '0};
  int  cyc, next_free, iss_cyc;
  bit  last_g;
  bit  iss_we;
  logic [AW-1:0] iss_addr;
  logic [DIN_W-1:0] iss_din;
  logic [1:0] exp_ready, exp_rsp;
  logic exp_we, exp_iss;
  logic [31:0] exp_rdata;
  int checks = 0, fails = 0;

  task automatic model_reset();
    pq.delete();
    next_free = cyc;
    iss_cyc = -100;
    last_g = 1'b1;
  endtask

  task automatic eval();
    bit e0, e1;
    int w;
    logic [AW-1:0] a;
    logic [DIN_W-1:0] d;
    bit we;
    #1;
    exp_rsp = '0;
    exp_rdata = '0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      exp_rsp = pq[0].owner ? 2'b10 : 2'b01;
      exp_rdata = pq[0].data;
      pq.delete(0);
    end
    exp_iss = (cyc == iss_cyc);
    exp_we = exp_iss && iss_we;
    e0 = req_valid[0] && !(req_we[0] && mem_full);
    e1 = req_valid[1] && !(req_we[1] && mem_full);
    exp_ready = '0;
    if (cyc >= next_free && (e0 || e1)) begin
      if (e0 && e1) w = RR ? (last_g ? 0 : 1) : 0;
      else w = e0 ? 0 : 1;
      exp_ready = (w == 0) ? 2'b01 : 2'b10;
      last_g = (w == 1);
      we = req_we[w];
      a = (w == 1) ? req_addr1 : req_addr0;
      d = (w == 1) ? req_wdata1 : req_wdata0;
      pq.push_back('{due: cyc + 3, owner: (w == 1),
                     data: we ? 32'h0 : {12'h0, ref_mem[a]}});
      if (we) ref_mem[a] = d;
      iss_cyc = cyc + 1;
      iss_we = we;
      iss_addr = a;
      iss_din = d;
      next_free = cyc + 3;
    end
  endtask

  // Advance one cycle; granted clients drop their request.
  task automatic adv();
    logic [1:0] r;
    r = req_ready;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    req_valid = req_valid & ~r;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, mem_address, mem_datain,
         mem_write_en} !== '0) begin
      fails++;
      $display("FAIL reset_async outputs rdy=%b rsp=%b rd=%h a=%h d=%h we=%b, want all 0",
               req_ready, rsp_valid, rsp_rdata, mem_address, mem_datain, mem_write_en);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready got %b want 00", req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;
    cyc = 0;
    model_reset();
    eval();
    checks++;
    if ({req_ready, rsp_valid, mem_write_en} !== 5'b0) begin
      fails++;
      $display("FAIL reset_idle got %b%b%b want 00000", req_ready, rsp_valid, mem_write_en);
    end
    adv();
  endtask

  task automatic test_write_read();
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        req_valid[0] = 1'b1; req_we[0] = 1'b1;
        req_addr0 = 8'h10; req_wdata0 = 20'h0ABCD;
      end
      if (k == 3) begin
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr0 = 8'h10;
      end
      eval();
      checks++;
      if ({req_ready, rsp_valid, mem_write_en} !== {exp_ready, exp_rsp, exp_we}) begin
        fails++;
        $display("FAIL wr_rd k=%0d rdy/rsp/we got %b/%b/%b want %b/%b/%b",
                 k, req_ready, rsp_valid, mem_write_en, exp_ready, exp_rsp, exp_we);
      end
      if (exp_iss) begin
        checks++;
        if (mem_address !== iss_addr || (exp_we && mem_datain !== iss_din)) begin
          fails++;
          $display("FAIL wr_rd_port k=%0d addr=%h din=%h want %h/%h",
                   k, mem_address, mem_datain, iss_addr, iss_din);
        end
      end
      if (k == 3 || k == 6) begin
        checks++;
        if (rsp_valid !== 2'b01 || (k == 6 && rsp_rdata !== 32'h0000ABCD)) begin
          fails++;
          $display("FAIL wr_rd_rsp k=%0d rsp=%b rd=%h want 01 rd=0000abcd",
                   k, rsp_valid, rsp_rdata);
        end
      end
      adv();
    end
  endtask

  task automatic test_contention();
    int ob0 = 0, ob1 = 0, prev = -1, alt_bad = 0;
    req_we = 2'b00;
    req_addr0 = 8'h01;
    req_addr1 = 8'h02;
    for (int k = 0; k < 19; k++) begin
      req_valid = 2'b11;
      eval();
      checks++;
      if ({req_ready, rsp_valid} !== {exp_ready, exp_rsp}) begin
        fails++;
        $display("FAIL contend k=%0d rdy/rsp got %b/%b want %b/%b",
                 k, req_ready, rsp_valid, exp_ready, exp_rsp);
      end
      if (exp_rsp != 0) begin
        checks++;
        if (rsp_rdata !== exp_rdata) begin
          fails++;
          $display("FAIL contend_data k=%0d got %h want %h", k, rsp_rdata, exp_rdata);
        end
      end
      if (req_ready == 2'b01) begin
        ob0++;
        if (prev == 0) alt_bad++;
        prev = 0;
      end
      if (req_ready == 2'b10) begin
        ob1++;
        if (prev == 1) alt_bad++;
        prev = 1;
      end
      adv();
    end
    req_valid = 2'b00;
    checks++;
`ifdef MEM_ARB_RR_EN
    if (alt_bad != 0 || ob0 + ob1 != 7) begin
      fails++;
      $display("FAIL contend_rr g0=%0d g1=%0d repeats=%0d want 7 alternating",
               ob0, ob1, alt_bad);
    end
`else
    if (ob1 != 0 || ob0 != 7) begin
      fails++;
      $display("FAIL contend_fixed g0=%0d g1=%0d want 7/0", ob0, ob1);
    end
`endif
    for (int k = 0; k < 3; k++) begin
      eval();
      adv();
    end
  endtask

  task automatic test_full();
    mem_full = 1'b1;
    req_valid = 2'b11;
    req_we = 2'b01;
    req_addr0 = 8'h30;
    req_wdata0 = 20'h5A5A5;
    req_addr1 = 8'h20;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) mem_full = 1'b0;
      eval();
      checks++;
      if ({req_ready, rsp_valid, mem_write_en} !== {exp_ready, exp_rsp, exp_we}) begin
        fails++;
        $display("FAIL full k=%0d rdy/rsp/we got %b/%b/%b want %b/%b/%b",
                 k, req_ready, rsp_valid, mem_write_en, exp_ready, exp_rsp, exp_we);
      end
      if (k == 0 || k == 3 || k == 5) begin
        checks++;
        if (req_ready !== ((k == 5) ? 2'b01 : (k == 0) ? 2'b10 : 2'b00)) begin
          fails++;
          $display("FAIL full_grant k=%0d got %b", k, req_ready);
        end
      end
      adv();
    end
  endtask

  task automatic test_rst_mid();
    req_valid = 2'b10;
    req_we = 2'b00;
    req_addr1 = 8'h10;
    for (int k = 0; k < 3; k++) begin
      eval();
      adv();
    end
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, mem_address, mem_datain,
         mem_write_en} !== '0) begin
      fails++;
      $display("FAIL rst_mid outputs rdy=%b rsp=%b rd=%h a=%h d=%h we=%b, want all 0",
               req_ready, rsp_valid, rsp_rdata, mem_address, mem_datain, mem_write_en);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    next_free = cyc;
    req_valid = 2'b01;
    req_addr0 = 8'h10;
    for (int k = 0; k < 5; k++) begin
      eval();
      checks++;
      if ({req_ready, rsp_valid} !== {exp_ready, exp_rsp}) begin
        fails++;
        $display("FAIL rst_mid k=%0d rdy/rsp got %b/%b want %b/%b",
                 k, req_ready, rsp_valid, exp_ready, exp_rsp);
      end
      if (k == 3) begin
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h0000ABCD) begin
          fails++;
          $display("FAIL rst_mid_rsp rsp=%b rd=%h want 01/0000abcd", rsp_valid, rsp_rdata);
        end
      end
      adv();
    end
  endtask

  task automatic test_top_addr();
    logic [DIN_W-1:0] v;
    v = DIN_W'($urandom);
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        req_valid[1] = 1'b1; req_we[1] = 1'b1;
        req_addr1 = 8'hFF; req_wdata1 = v;
      end
      if (k == 3) begin
        req_valid[1] = 1'b1; req_we[1] = 1'b0;
      end
      eval();
      if (exp_iss) begin
        checks++;
        if (mem_address !== 8'hFF) begin
          fails++;
          $display("FAIL top_addr_port k=%0d addr=%h want ff", k, mem_address);
        end
      end
      if (k == 6) begin
        checks++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== {12'h0, v}) begin
          fails++;
          $display("FAIL top_addr_rd rsp=%b rd=%h want 10/%h", rsp_valid, rsp_rdata, {12'h0, v});
        end
      end
      adv();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (!req_valid[0] && $urandom_range(0, 1) == 1) begin
        req_valid[0] = 1'b1;
        req_we[0] = 1'($urandom);
        req_addr0 = AW'($urandom);
        req_wdata0 = DIN_W'($urandom);
      end
      if (!req_valid[1] && $urandom_range(0, 1) == 1) begin
        req_valid[1] = 1'b1;
        req_we[1] = 1'($urandom);
        req_addr1 = AW'($urandom_range(0, 15));
        req_wdata1 = DIN_W'($urandom);
      end
      mem_full = ($urandom_range(0, 3) == 0);
      eval();
      checks++;
      if ({req_ready, rsp_valid, mem_write_en} !== {exp_ready, exp_rsp, exp_we}) begin
        fails++;
        $display("FAIL random k=%0d rdy/rsp/we got %b/%b/%b want %b/%b/%b",
                 k, req_ready, rsp_valid, mem_write_en, exp_ready, exp_rsp, exp_we);
      end
      if (exp_rsp != 0) begin
        checks++;
        if (rsp_rdata !== exp_rdata) begin
          fails++;
          $display("FAIL random_data k=%0d got %h want %h", k, rsp_rdata, exp_rdata);
        end
      end
      if (exp_iss) begin
        checks++;
        if (mem_address !== iss_addr || (exp_we && mem_datain !== iss_din)) begin
          fails++;
          $display("FAIL random_port k=%0d addr=%h din=%h want %h/%h",
                   k, mem_address, mem_datain, iss_addr, iss_din);
        end
      end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_full();
    test_rst_mid();
    test_top_addr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
